// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: registered forwarding selects, load-use stall
// with bubble injection, and multi-cycle front-end flush on mispredict.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned REG_W        = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             decode_v,
  input  logic [REG_W-1:0] decode_rs1,
  input  logic [REG_W-1:0] decode_rs2,
  input  logic             decode_rs1_used,
  input  logic             decode_rs2_used,
  input  logic             rfetch_v,
  input  logic [REG_W-1:0] rfetch_rd,
  input  logic             rfetch_wb_v,
  input  logic             rfetch_load_v,
  input  logic [REG_W-1:0] execute_rd,
  input  logic             execute_wb_v,
  input  logic             execute_mispredict_v,
  output logic             forwarding_execute_rs1_v,
  output logic             forwarding_execute_rs2_v,
  output logic             forwarding_memory_rs1_v,
  output logic             forwarding_memory_rs2_v,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int unsigned          CNT_W      = 4;
  localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fwd_ex1_q, fwd_ex2_q, fwd_mem1_q, fwd_mem2_q;
  logic fwd_ex1_d, fwd_ex2_d, fwd_mem1_d, fwd_mem2_d;

  logic m_ex1, m_ex2, m_mem1, m_mem2;
  logic load_use;
  logic flush_int, stall_int;

  // Producer matches against decode sources; x0 never matches.
  always_comb begin
    m_ex1  = decode_v & decode_rs1_used & rfetch_v & rfetch_wb_v &
             (rfetch_rd == decode_rs1) & (decode_rs1 != '0);
    m_ex2  = decode_v & decode_rs2_used & rfetch_v & rfetch_wb_v &
             (rfetch_rd == decode_rs2) & (decode_rs2 != '0);
    m_mem1 = decode_v & decode_rs1_used & execute_wb_v &
             (execute_rd == decode_rs1) & (decode_rs1 != '0);
    m_mem2 = decode_v & decode_rs2_used & execute_wb_v &
             (execute_rd == decode_rs2) & (decode_rs2 != '0);
    load_use = (m_ex1 | m_ex2) & rfetch_load_v;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (execute_mispredict_v) begin
      state_d = FLUSH;
      cnt_d   = CNT_RELOAD;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_use) state_d = STALL;
        end
        FLUSH: begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        STALL:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Outputs forced low while reset is asserted, independent of inputs.
  always_comb begin
    flush_int = rst_ni & (execute_mispredict_v | (state_q == FLUSH));
    stall_int = rst_ni & (state_d == STALL);
  end

  // A flushed or stalled cycle puts a bubble in rfetch, so nothing forwards.
  always_comb begin
    fwd_ex1_d  = 1'b0;
    fwd_ex2_d  = 1'b0;
    fwd_mem1_d = 1'b0;
    fwd_mem2_d = 1'b0;
    if (!(flush_int | stall_int)) begin
      fwd_ex1_d  = m_ex1 & ~rfetch_load_v;
      fwd_ex2_d  = m_ex2 & ~rfetch_load_v;
      fwd_mem1_d = m_mem1 & ~m_ex1;
      fwd_mem2_d = m_mem2 & ~m_ex2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      fwd_ex1_q  <= 1'b0;
      fwd_ex2_q  <= 1'b0;
      fwd_mem1_q <= 1'b0;
      fwd_mem2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fwd_ex1_q  <= fwd_ex1_d;
      fwd_ex2_q  <= fwd_ex2_d;
      fwd_mem1_q <= fwd_mem1_d;
      fwd_mem2_q <= fwd_mem2_d;
    end
  end

  assign forwarding_execute_rs1_v = fwd_ex1_q;
  assign forwarding_execute_rs2_v = fwd_ex2_q;
  assign forwarding_memory_rs1_v  = fwd_mem1_q;
  assign forwarding_memory_rs2_v  = fwd_mem2_q;
  assign stall_o                  = stall_int;
  assign flush_o                  = flush_int;
  assign bubble_o                 = stall_int | flush_int;
  assign state_o                  = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_hazard_ctrl;
  localparam int unsigned FC = 2;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  logic rst_ni;
  logic decode_v, decode_rs1_used, decode_rs2_used;
  logic [RW-1:0] decode_rs1, decode_rs2, rfetch_rd, execute_rd;
  logic rfetch_v, rfetch_wb_v, rfetch_load_v, execute_wb_v, mis;
  logic fe1, fe2, fm1, fm2, stall, bubble, flush;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // Model state: remaining flush cycles after the current one, stall-state flag,
  // and the forwarding selects expected after the next edge ({fe1,fe2,fm1,fm2}).
  int       m_flush_left;
  bit       m_stalled;
  logic [3:0] m_fwd;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_W(RW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .decode_v(decode_v), .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
    .decode_rs1_used(decode_rs1_used), .decode_rs2_used(decode_rs2_used),
    .rfetch_v(rfetch_v), .rfetch_rd(rfetch_rd), .rfetch_wb_v(rfetch_wb_v),
    .rfetch_load_v(rfetch_load_v), .execute_rd(execute_rd),
    .execute_wb_v(execute_wb_v), .execute_mispredict_v(mis),
    .forwarding_execute_rs1_v(fe1), .forwarding_execute_rs2_v(fe2),
    .forwarding_memory_rs1_v(fm1), .forwarding_memory_rs2_v(fm2),
    .stall_o(stall), .bubble_o(bubble), .flush_o(flush), .state_o(state)
  );

  task automatic idle_inputs();
    decode_v = 0; decode_rs1 = '0; decode_rs2 = '0;
    decode_rs1_used = 0; decode_rs2_used = 0;
    rfetch_v = 0; rfetch_rd = '0; rfetch_wb_v = 0; rfetch_load_v = 0;
    execute_rd = '0; execute_wb_v = 0; mis = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [8:0] all;
    rst_ni = 0; idle_inputs();
    #12;
    all = {fe1, fe2, fm1, fm2, stall, bubble, flush, state};
    total++; if (all !== 9'd0) begin bad++; $display("FAIL reset_por got=%b exp=%b", all, 9'd0); end
    @(negedge clk); rst_ni = 1;
    tick();
    mis = 1; tick(); mis = 0; #1;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL reset_preflush state got=%0d exp=2", state); end
    #2; rst_ni = 0; #1;
    all = {fe1, fe2, fm1, fm2, stall, bubble, flush, state};
    total++; if (all !== 9'd0) begin bad++; $display("FAIL reset_async got=%b exp=%b", all, 9'd0); end
    @(negedge clk); rst_ni = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      all = {fe1, fe2, fm1, fm2, stall, bubble, flush, state};
      total++; if (all !== 9'd0) begin bad++; $display("FAIL reset_after got=%b exp=%b", all, 9'd0); end
    end
  endtask

  task automatic test_fwd_execute();
    idle_inputs();
    rfetch_v = 1; rfetch_rd = 5; rfetch_wb_v = 1;
    decode_v = 1; decode_rs1 = 5; decode_rs1_used = 1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fwdex_stall got=%b exp=0", stall); end
    tick();
    total++; if ({fe1, fm1} !== 2'b10) begin bad++; $display("FAIL fwdex_sel got=%b exp=10", {fe1, fm1}); end
    idle_inputs(); tick();
  endtask

  task automatic test_double_producer();
    idle_inputs();
    rfetch_v = 1; rfetch_rd = 7; rfetch_wb_v = 1;
    execute_rd = 7; execute_wb_v = 1;
    decode_v = 1; decode_rs2 = 7; decode_rs2_used = 1;
    tick();
    total++; if ({fe2, fm2} !== 2'b10) begin bad++; $display("FAIL dbl_young got=%b exp=10", {fe2, fm2}); end
    rfetch_wb_v = 0;
    tick();
    total++; if ({fe2, fm2} !== 2'b01) begin bad++; $display("FAIL dbl_mem got=%b exp=01", {fe2, fm2}); end
    idle_inputs(); tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    rfetch_v = 1; rfetch_rd = 3; rfetch_wb_v = 1; rfetch_load_v = 1;
    decode_v = 1; decode_rs1 = 3; decode_rs1_used = 1;
    #1;
    total++; if ({stall, bubble, flush} !== 3'b110) begin bad++; $display("FAIL lu_detect got=%b exp=110", {stall, bubble, flush}); end
    tick();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL lu_state got=%0d exp=1", state); end
    total++; if ({fe1, fe2, fm1, fm2} !== 4'b0) begin bad++; $display("FAIL lu_fwd0 got=%b exp=0000", {fe1, fe2, fm1, fm2}); end
    rfetch_v = 0; rfetch_wb_v = 0; rfetch_load_v = 0;
    execute_rd = 3; execute_wb_v = 1;
    #1;
    total++; if ({stall, bubble} !== 2'b00) begin bad++; $display("FAIL lu_onecycle got=%b exp=00", {stall, bubble}); end
    tick();
    total++; if ({state, fe1, fm1} !== 4'b0001) begin bad++; $display("FAIL lu_memfwd got=%b exp=0001", {state, fe1, fm1}); end
    idle_inputs(); tick();
  endtask

  task automatic test_mispredict();
    int n;
    idle_inputs();
    rfetch_v = 1; rfetch_rd = 5; rfetch_wb_v = 1;
    decode_v = 1; decode_rs1 = 5; decode_rs1_used = 1;
    mis = 1; #1;
    total++; if ({flush, bubble, stall, state} !== 5'b11000) begin bad++; $display("FAIL mp_c0 got=%b exp=11000", {flush, bubble, stall, state}); end
    tick(); mis = 0; #1;
    for (int c = 1; c <= 2; c++) begin
      total++; if ({flush, state, fe1, fe2, fm1, fm2} !== 7'b1100000) begin bad++; $display("FAIL mp_c%0d got=%b exp=1100000", c, {flush, state, fe1, fe2, fm1, fm2}); end
      tick();
    end
    total++; if ({flush, state, fe1, fe2, fm1, fm2} !== 7'b0000000) begin bad++; $display("FAIL mp_end got=%b exp=0000000", {flush, state, fe1, fe2, fm1, fm2}); end
    tick();
    total++; if (fe1 !== 1'b1) begin bad++; $display("FAIL mp_resume got=%b exp=1", fe1); end
    idle_inputs();
    mis = 1; tick();
    #1;
    total++; if ({flush, state} !== 3'b110) begin bad++; $display("FAIL mp_repulse got=%b exp=110", {flush, state}); end
    tick(); mis = 0; #1;
    n = 0;
    while (flush === 1'b1 && n < 10) begin n++; tick(); end
    total++; if (n !== 2) begin bad++; $display("FAIL mp_extend got=%0d exp=2", n); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL mp_extend_state got=%0d exp=0", state); end
  endtask

  task automatic test_x0_collision();
    idle_inputs();
    rfetch_v = 1; rfetch_rd = 0; rfetch_wb_v = 1; rfetch_load_v = 1;
    execute_rd = 0; execute_wb_v = 1;
    decode_v = 1; decode_rs1 = 0; decode_rs1_used = 1; decode_rs2 = 0; decode_rs2_used = 1;
    #1;
    total++; if ({stall, bubble} !== 2'b00) begin bad++; $display("FAIL x0_stall got=%b exp=00", {stall, bubble}); end
    tick();
    total++; if ({fe1, fe2, fm1, fm2, state} !== 6'b0) begin bad++; $display("FAIL x0_fwd got=%b exp=000000", {fe1, fe2, fm1, fm2, state}); end
    rfetch_rd = 3; decode_rs1 = 3; mis = 1;
    #1;
    total++; if ({stall, flush, bubble} !== 3'b011) begin bad++; $display("FAIL coll_out got=%b exp=011", {stall, flush, bubble}); end
    tick();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL coll_state got=%0d exp=2", state); end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_random();
    bit e1, e2, mm1, mm2, lu, in_fl, x_fl, x_st;
    logic [1:0] x_state;
    idle_inputs();
    repeat (3) tick();
    m_flush_left = 0; m_stalled = 0; m_fwd = '0;
    for (int i = 0; i < 400; i++) begin
      decode_v = 1'($urandom_range(0, 1)) | 1'($urandom_range(0, 1));
      decode_rs1 = RW'($urandom_range(0, 3)); decode_rs2 = RW'($urandom_range(0, 3));
      decode_rs1_used = 1'($urandom_range(0, 1)); decode_rs2_used = 1'($urandom_range(0, 1));
      rfetch_v = 1'($urandom_range(0, 1)); rfetch_rd = RW'($urandom_range(0, 3));
      rfetch_wb_v = 1'($urandom_range(0, 1)); rfetch_load_v = 1'($urandom_range(0, 1));
      execute_rd = RW'($urandom_range(0, 3)); execute_wb_v = 1'($urandom_range(0, 1));
      mis = ($urandom_range(0, 15) == 0);
      #1;
      e1  = decode_v && decode_rs1_used && rfetch_v && rfetch_wb_v && rfetch_rd == decode_rs1 && decode_rs1 != 0;
      e2  = decode_v && decode_rs2_used && rfetch_v && rfetch_wb_v && rfetch_rd == decode_rs2 && decode_rs2 != 0;
      mm1 = decode_v && decode_rs1_used && execute_wb_v && execute_rd == decode_rs1 && decode_rs1 != 0;
      mm2 = decode_v && decode_rs2_used && execute_wb_v && execute_rd == decode_rs2 && decode_rs2 != 0;
      lu  = (e1 || e2) && rfetch_load_v;
      in_fl = (m_flush_left > 0);
      x_fl = mis || in_fl;
      x_st = !mis && !in_fl && !m_stalled && lu;
      x_state = in_fl ? 2'd2 : (m_stalled ? 2'd1 : 2'd0);
      total++;
      if ({flush, stall, bubble, state} !== {x_fl, x_st, x_fl | x_st, x_state}) begin
        bad++; $display("FAIL rnd_ctl[%0d] got=%b exp=%b", i, {flush, stall, bubble, state}, {x_fl, x_st, x_fl | x_st, x_state});
      end
      total++;
      if ({fe1, fe2, fm1, fm2} !== m_fwd) begin
        bad++; $display("FAIL rnd_fwd[%0d] got=%b exp=%b", i, {fe1, fe2, fm1, fm2}, m_fwd);
      end
      m_fwd = (x_fl || x_st) ? 4'b0 :
              {e1 && !rfetch_load_v, e2 && !rfetch_load_v, mm1 && !e1, mm2 && !e2};
      m_flush_left = mis ? FC : (in_fl ? m_flush_left - 1 : 0);
      m_stalled = x_st;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fwd_execute();
    test_double_producer();
    test_load_use();
    test_mispredict();
    test_x0_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the rfetch/execute/memory datapath.
- Computes the execute-stage forwarding selects one cycle early and registers them, so they are valid when the consuming instruction reaches execute.
- Detects load-use hazards and stalls fetch/decode for one cycle with a bubble injected into rfetch.
- Sequences a multi-cycle front-end flush on branch mispredict.

Parameters:
- FLUSH_CYCLES, 2: cycles flush_o is held after a mispredict (1..15).
- REG_W, 5: register-index width (rvga_reg).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- decode_v  in  1  decode holds a valid instruction
- decode_rs1  in  REG_W  decode source 1 index
- decode_rs2  in  REG_W  decode source 2 index
- decode_rs1_used  in  1  instruction reads rs1
- decode_rs2_used  in  1  instruction reads rs2
- rfetch_v  in  1  rfetch holds a valid instruction
- rfetch_rd  in  REG_W  rfetch destination
- rfetch_wb_v  in  1  rfetch instruction writes rd
- rfetch_load_v  in  1  rfetch instruction is a load
- execute_rd  in  REG_W  execute destination
- execute_wb_v  in  1  execute instruction writes rd and is not a bubble
- execute_mispredict_v  in  1  registered branch mispredict from execute
- forwarding_execute_rs1_v  out  1  select execute_result for rs1
- forwarding_execute_rs2_v  out  1  select execute_result for rs2
- forwarding_memory_rs1_v  out  1  select memory_result for rs1
- forwarding_memory_rs2_v  out  1  select memory_result for rs2
- stall_o  out  1  hold PC and decode register
- bubble_o  out  1  load NOP into rfetch next edge
- flush_o  out  1  kill fetch, decode and rfetch contents
- state_o  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs 0; state RUN; flush counter 0. Deassertion is sampled on clk_i.
- Match terms (combinational):
  - mE_x = decode_v & decode_rsx_used & rfetch_v & rfetch_wb_v & (rfetch_rd == decode_rsx) & (decode_rsx != 0)
  - mM_x = decode_v & decode_rsx_used & execute_wb_v & (execute_rd == decode_rsx) & (decode_rsx != 0)
- load_use = (mE_1 | mE_2) & rfetch_load_v.
- FSM, evaluated each cycle, priority from highest:
  1. execute_mispredict_v=1, any state: go to FLUSH, counter <= FLUSH_CYCLES-1.
  2. RUN with load_use: go to STALL.
  3. FLUSH: if counter==0 go to RUN, else counter-1.
  4. STALL: go to RUN unconditionally. A load cannot sit in rfetch twice in a row, because rfetch holds a bubble.
- A mispredict during FLUSH restarts the counter.
- A mispredict in the same cycle as load_use: the flush wins, and no STALL is entered.
- Combinational outputs:
  - stall_o = (state_next==STALL), i.e. asserted the same cycle load_use is detected in RUN.
  - bubble_o = stall_o | flush_o.
  - flush_o = execute_mispredict_v | (state==FLUSH).
  - Total flush length = 1 + FLUSH_CYCLES cycles.
- Forwarding registers: updated every edge.
  - If flush_o or stall_o: next forwarding = 0, because rfetch receives a bubble.
  - Else forwarding_execute_x <= mE_x & ~rfetch_load_v.
  - Else forwarding_memory_x <= mM_x & ~mE_x & ~(mE_x & rfetch_load_v). The youngest producer wins; execute and memory selects are never both 1 for the same source.
- Latency: forwarding selects appear exactly one cycle after the decode-side match, aligned with the instruction in execute.
- x0 is never forwarded and never stalls.
- state_o reflects the registered state.

Test Plan:
- Reset: drive rst_ni low mid-FLUSH (counter=1) asynchronously -> all outputs 0 immediately, state_o=0; after release with no hazards, outputs stay 0.
- RAW forwarding from execute: rfetch_rd=5, rfetch_wb_v=1, no load; decode_rs1=5, rs1_used=1 -> next cycle forwarding_execute_rs1_v=1, forwarding_memory_rs1_v=0, no stall.
- Double producer: rfetch_rd=7 and execute_rd=7, both writing; decode_rs2=7 -> next cycle forwarding_execute_rs2_v=1 only. With rfetch_wb_v=0 -> forwarding_memory_rs2_v=1 only.
- Load-use: rfetch_load_v=1, rfetch_rd=3, decode_rs1=3 -> stall_o=bubble_o=1 for exactly 1 cycle, state_o=1. Next cycle (load now in execute, execute_rd=3) -> then forwarding_memory_rs1_v=1 one cycle later.
- Mispredict, FLUSH_CYCLES=2: one-cycle execute_mispredict_v pulse -> flush_o=1 for 3 cycles, state_o=2 for 2 cycles, all forwarding outputs 0 throughout. A second pulse on flush cycle 2 -> flush extends to 2 more cycles.
- x0 and collision: decode_rs1=0 matching a writing rfetch_rd=0 -> no forwarding, no stall. Mispredict simultaneous with load_use -> stall_o=0, flush_o=1.
